scpu_ctrl_more: RTL and testbench

Main control decoder for the single-cycle MIPS CPU.
- Decodes OPcode/Fun (plus ALU zero flag) into datapath controls: register-file destination/write, ALU operand and operation, write-back source, memory access, next-PC select.
- Outputs are registered: a decoded instruction's controls appear one clock after it is presented.
- Sits between instruction fetch and the datapath/memory-IO bus.

---
 rtl/scpu_ctrl_more.sv | 198 +++++++++++++++++++
 tb/tb_scpu_ctrl_more.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/scpu_ctrl_more.sv
// Main control decoder for the single-cycle MIPS CPU; all controls registered (1-cycle latency).
// Optional: define MIO_STALL_EN to suppress lw/sw write-back, store and branch while MIO_ready is low.
module scpu_ctrl_more (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OPcode,
    input  logic [5:0] Fun,
    input  logic       MIO_ready,
    input  logic       zero,
    output logic       RegDst,
    output logic       ALUSrc_B,
    output logic [1:0] DatatoReg,
    output logic       Jal,
    output logic [1:0] Branch,
    output logic       RegWrite,
    output logic [2:0] ALU_Control,
    output logic       mem_w,
    output logic       CPU_MIO
);
    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] FN_SRL  = 6'b000010;
    localparam logic [OP_W-1:0] FN_JR   = 6'b001000;
    localparam logic [OP_W-1:0] FN_JALR = 6'b001001;
    localparam logic [OP_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND  = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
    localparam logic [OP_W-1:0] FN_XOR  = 6'b100110;
    localparam logic [OP_W-1:0] FN_NOR  = 6'b100111;
    localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_XOR = 3'b011;
    localparam logic [ALU_W-1:0] ALU_NOR = 3'b100;
    localparam logic [ALU_W-1:0] ALU_SRL = 3'b101;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_LUI = 2'b10;
    localparam logic [1:0] WB_PC4 = 2'b11;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_REG = 2'b11;

    logic             reg_dst_c;
    logic             alusrc_b_c;
    logic [1:0]       data_to_reg_c;
    logic             jal_c;
    logic [1:0]       branch_c;
    logic             reg_write_c;
    logic [ALU_W-1:0] alu_ctrl_c;
    logic             mem_w_c;
    logic             cpu_mio_c;

    // Combinational decode of the instruction currently presented
    always_comb begin
        reg_dst_c     = 1'b0;
        alusrc_b_c    = 1'b0;
        data_to_reg_c = WB_ALU;
        jal_c         = 1'b0;
        branch_c      = PC_SEQ;
        reg_write_c   = 1'b0;
        alu_ctrl_c    = ALU_AND;
        mem_w_c       = 1'b0;
        cpu_mio_c     = 1'b0;
        unique case (OPcode)
            OP_RTYPE: begin
                unique case (Fun)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOR, FN_XOR, FN_SRL: begin
                        reg_dst_c   = 1'b1;
                        reg_write_c = 1'b1;
                        unique case (Fun)
                            FN_ADD:  alu_ctrl_c = ALU_ADD;
                            FN_SUB:  alu_ctrl_c = ALU_SUB;
                            FN_AND:  alu_ctrl_c = ALU_AND;
                            FN_OR:   alu_ctrl_c = ALU_OR;
                            FN_SLT:  alu_ctrl_c = ALU_SLT;
                            FN_NOR:  alu_ctrl_c = ALU_NOR;
                            FN_XOR:  alu_ctrl_c = ALU_XOR;
                            default: alu_ctrl_c = ALU_SRL;
                        endcase
                    end
                    FN_JR:   branch_c = PC_REG;
                    FN_JALR: begin
                        branch_c      = PC_REG;
                        reg_dst_c     = 1'b1;
                        reg_write_c   = 1'b1;
                        data_to_reg_c = WB_PC4;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                alusrc_b_c  = 1'b1;
                reg_write_c = 1'b1;
                unique case (OPcode)
                    OP_ADDI: alu_ctrl_c = ALU_ADD;
                    OP_SLTI: alu_ctrl_c = ALU_SLT;
                    OP_ANDI: alu_ctrl_c = ALU_AND;
                    OP_ORI:  alu_ctrl_c = ALU_OR;
                    default: alu_ctrl_c = ALU_XOR;
                endcase
            end
            OP_LUI: begin
                reg_write_c   = 1'b1;
                data_to_reg_c = WB_LUI;
            end
            OP_LW: begin
                alusrc_b_c    = 1'b1;
                alu_ctrl_c    = ALU_ADD;
                data_to_reg_c = WB_MEM;
                reg_write_c   = 1'b1;
                cpu_mio_c     = 1'b1;
            end
            OP_SW: begin
                alusrc_b_c = 1'b1;
                alu_ctrl_c = ALU_ADD;
                mem_w_c    = 1'b1;
                cpu_mio_c  = 1'b1;
            end
            OP_BEQ: begin
                alu_ctrl_c = ALU_SUB;
                branch_c   = zero ? PC_BR : PC_SEQ;
            end
            OP_BNE: begin
                alu_ctrl_c = ALU_SUB;
                branch_c   = zero ? PC_SEQ : PC_BR;
            end
            OP_J: branch_c = PC_J;
            OP_JAL: begin
                branch_c      = PC_J;
                jal_c         = 1'b1;
                reg_write_c   = 1'b1;
                data_to_reg_c = WB_PC4;
            end
            default: ;
        endcase
`ifdef MIO_STALL_EN
        // Hold off architectural side effects until the bus is ready
        if ((OPcode == OP_LW || OPcode == OP_SW) && !MIO_ready) begin
            reg_write_c = 1'b0;
            mem_w_c     = 1'b0;
            branch_c    = PC_SEQ;
        end
`endif
    end

`ifndef MIO_STALL_EN
    logic unused_mio_ready;
    assign unused_mio_ready = MIO_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegDst      <= 1'b0;
            ALUSrc_B    <= 1'b0;
            DatatoReg   <= 2'b00;
            Jal         <= 1'b0;
            Branch      <= 2'b00;
            RegWrite    <= 1'b0;
            ALU_Control <= 3'b000;
            mem_w       <= 1'b0;
            CPU_MIO     <= 1'b0;
        end else begin
            RegDst      <= reg_dst_c;
            ALUSrc_B    <= alusrc_b_c;
            DatatoReg   <= data_to_reg_c;
            Jal         <= jal_c;
            Branch      <= branch_c;
            RegWrite    <= reg_write_c;
            ALU_Control <= alu_ctrl_c;
            mem_w       <= mem_w_c;
            CPU_MIO     <= cpu_mio_c;
        end
    end
endmodule

// File: tb/tb_scpu_ctrl_more.sv
// Bench for scpu_ctrl_more: directed plan steps plus random opcodes against a table-driven model.
module tb_scpu_ctrl_more;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] OPcode = '0;
    logic [5:0] Fun = '0;
    logic       MIO_ready = 1'b1;
    logic       zero = 1'b0;
    logic       RegDst, ALUSrc_B, Jal, RegWrite, mem_w, CPU_MIO;
    logic [1:0] DatatoReg, Branch;
    logic [2:0] ALU_Control;

    int total = 0;
    int bad = 0;

`ifdef MIO_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    typedef struct packed {
        logic       rd;
        logic       asb;
        logic [1:0] d2r;
        logic       jal;
        logic [1:0] br;
        logic       rw;
        logic [2:0] alu;
        logic       mw;
        logic       mio;
    } ctrl_t;

    scpu_ctrl_more dut (
        .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun(Fun),
        .MIO_ready(MIO_ready), .zero(zero),
        .RegDst(RegDst), .ALUSrc_B(ALUSrc_B), .DatatoReg(DatatoReg), .Jal(Jal),
        .Branch(Branch), .RegWrite(RegWrite), .ALU_Control(ALU_Control),
        .mem_w(mem_w), .CPU_MIO(CPU_MIO)
    );

    always #5 clk = ~clk;

    // Instruction tables: ALU op per R-type funct and per immediate-ALU opcode
    logic [2:0] alu_r [logic [5:0]];
    logic [2:0] alu_i [logic [5:0]];
    logic [5:0] valid_ops [$];
    logic [5:0] valid_funs [$];

    function automatic ctrl_t model(input logic [5:0] op, input logic [5:0] fn,
                                    input logic z, input logic rdy);
        ctrl_t c = '0;
        if (op == 6'd0) begin
            if (alu_r.exists(fn)) begin
                c.rd = 1; c.rw = 1; c.alu = alu_r[fn];
            end else if (fn == 6'b001000) begin
                c.br = 2'b11;
            end else if (fn == 6'b001001) begin
                c.br = 2'b11; c.rd = 1; c.rw = 1; c.d2r = 2'b11;
            end
        end else if (alu_i.exists(op)) begin
            c.asb = 1; c.rw = 1; c.alu = alu_i[op];
        end else if (op == 6'b001111) begin
            c.rw = 1; c.d2r = 2'b10;
        end else if (op == 6'b100011 || op == 6'b101011) begin
            c.asb = 1; c.alu = 3'b010; c.mio = 1;
            if (op == 6'b100011) begin c.rw = 1; c.d2r = 2'b01; end
            else c.mw = 1;
            if (STALL && !rdy) begin c.rw = 0; c.mw = 0; c.br = 2'b00; end
        end else if (op == 6'b000100 || op == 6'b000101) begin
            c.alu = 3'b110;
            c.br = ((op == 6'b000100) == z) ? 2'b01 : 2'b00;
        end else if (op == 6'b000010) begin
            c.br = 2'b10;
        end else if (op == 6'b000011) begin
            c.br = 2'b10; c.jal = 1; c.rw = 1; c.d2r = 2'b11;
        end
        return c;
    endfunction

    task automatic check(input string tag, input ctrl_t exp);
        ctrl_t obs;
        obs = '{RegDst, ALUSrc_B, DatatoReg, Jal, Branch, RegWrite, ALU_Control, mem_w, CPU_MIO};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (rd,asb,d2r,jal,br,rw,alu,mw,mio)",
                   tag, obs, exp);
        end
    endtask

    // Present one instruction, clock it, and check the registered controls
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy);
        @(negedge clk);
        OPcode = op; Fun = fn; zero = z; MIO_ready = rdy;
        @(posedge clk);
        #1;
        check(tag, model(op, fn, z, rdy));
    endtask

    initial begin
        logic [5:0] op, fn;
        alu_r[6'b100000] = 3'b010; alu_r[6'b100010] = 3'b110;
        alu_r[6'b100100] = 3'b000; alu_r[6'b100101] = 3'b001;
        alu_r[6'b101010] = 3'b111; alu_r[6'b100111] = 3'b100;
        alu_r[6'b100110] = 3'b011; alu_r[6'b000010] = 3'b101;
        alu_i[6'b001000] = 3'b010; alu_i[6'b001010] = 3'b111;
        alu_i[6'b001100] = 3'b000; alu_i[6'b001101] = 3'b001;
        alu_i[6'b001110] = 3'b011;
        valid_ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c,
                      6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
        valid_funs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h26, 6'h02,
                       6'h08, 6'h09};

        OPcode = 6'b000011;
        #2;
        check("reset_hold", '0);
        @(negedge clk);
        rst_n = 1'b1;
        step("jal_pre", 6'b000011, 6'd0, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle clears everything without an edge
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_async", '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("jal_after_reset", '{0, 0, 2'b11, 1, 2'b10, 1, 3'b000, 0, 0});

        step("addi", 6'b001000, 6'd0, 1'b0, 1'b1);
        check("addi_const", '{0, 1, 2'b00, 0, 2'b00, 1, 3'b010, 0, 0});
        step("add", 6'b000000, 6'b100000, 1'b0, 1'b1);
        check("add_const", '{1, 0, 2'b00, 0, 2'b00, 1, 3'b010, 0, 0});
        step("jr", 6'b000000, 6'b001000, 1'b1, 1'b1);
        step("jalr", 6'b000000, 6'b001001, 1'b0, 1'b1);
        check("jalr_const", '{1, 0, 2'b11, 0, 2'b11, 1, 3'b000, 0, 0});
        step("lui", 6'b001111, 6'd0, 1'b0, 1'b1);
        step("lw", 6'b100011, 6'd0, 1'b0, 1'b1);
        check("lw_const", '{0, 1, 2'b01, 0, 2'b00, 1, 3'b010, 0, 1});
        step("sw", 6'b101011, 6'd0, 1'b0, 1'b1);
        check("sw_const", '{0, 1, 2'b00, 0, 2'b00, 0, 3'b010, 1, 1});
        step("beq_z1", 6'b000100, 6'd0, 1'b1, 1'b1);
        check("beq_z1_const", '{0, 0, 2'b00, 0, 2'b01, 0, 3'b110, 0, 0});
        step("beq_z0", 6'b000100, 6'd0, 1'b0, 1'b1);
        step("bne_z1", 6'b000101, 6'd0, 1'b1, 1'b1);
        step("bne_z0", 6'b000101, 6'd0, 1'b0, 1'b1);
        check("bne_z0_const", '{0, 0, 2'b00, 0, 2'b01, 0, 3'b110, 0, 0});
        step("illegal_op", 6'b111111, 6'b100000, 1'b1, 1'b0);
        check("illegal_const", '0);
        step("illegal_fun", 6'b000000, 6'b111111, 1'b1, 1'b1);
        step("lw_notready", 6'b100011, 6'd0, 1'b0, 1'b0);
        step("sw_notready", 6'b101011, 6'd0, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) begin
            step($sformatf("sweep_op%0d", i), valid_ops[i], 6'h20, 1'b0, 1'b1);
        end

        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 3) != 0) ? valid_ops[$urandom_range(0, 12)]
                                             : 6'($urandom);
            fn = ($urandom_range(0, 3) != 0) ? valid_funs[$urandom_range(0, 9)]
                                             : 6'($urandom);
            step($sformatf("rand%0d_op%b_fn%b", i, op, fn), op, fn,
                 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
